// File: rtl/spi_pkg.sv
// Shared constants for the APB SPI responder: register map, bit positions, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_pkg;

  // register addresses
  localparam logic [2:0] ADDR_CR = 3'b000;
  localparam logic [2:0] ADDR_SR = 3'b011;
  localparam logic [2:0] ADDR_DR = 3'b101;

  // CR bit positions; unlisted bits read as zero
  localparam int CR_SPIE  = 7;
  localparam int CR_SPE   = 6;
  localparam int CR_CPOL  = 3;
  localparam int CR_CPHA  = 2;
  localparam int CR_LSBFE = 0;
  localparam logic [7:0] CR_MASK = 8'hCD;

  // SR bit positions
  localparam int SR_RXF  = 7;
  localparam int SR_TXE  = 5;
  localparam int SR_OVR  = 4;
  localparam int SR_ABRT = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } spi_state_t;

endpackage

// File: rtl/spi_slave_shifter.sv
// SPI pin front end: synchronizers, sclk/ss edge detect, TX/RX shift registers, bit counter.
// Latency: pin edge to sample/shift action SYNC_STAGES+1 PCLK; miso is registered.
// Backpressure: none; pins are sampled every PCLK and events are single-cycle pulses.
module spi_slave_shifter
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       sclk,
  input  logic       ss,
  input  logic       mosi,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       lsbfe,
  input  logic       load,
  input  logic [7:0] load_byte,
  input  logic       shifting,
  output logic       ss_low,
  output logic       ss_fall,
  output logic       ss_rise,
  output logic       frame_done,
  output logic       abort,
  output logic       miso,
  output logic [7:0] rx_byte
);

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic sclk_s, ss_s, mosi_s, sclk_prev, ss_prev;
  logic sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic do_sample, do_shift;
  logic [7:0] tx_sr, rx_sr;
  logic [3:0] bitcnt;

  // Synchronize the asynchronous pins and keep one cycle of history for edge detection
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      ss_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_s;
      ss_prev   <= ss_s;
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sclk_rise  = sclk_s & ~sclk_prev;
  assign sclk_fall  = ~sclk_s & sclk_prev;
  assign lead_edge  = cpol ? sclk_fall : sclk_rise;
  assign trail_edge = cpol ? sclk_rise : sclk_fall;

  assign ss_low  = ~ss_s;
  assign ss_fall = ~ss_s & ss_prev;
  assign ss_rise = ss_s & ~ss_prev;

  // A shift edge with bitcnt==0 is either the CPHA=1 first edge (bit already on miso)
  // or the CPHA=0 final trailing edge of the previous frame; both must be ignored.
  assign do_sample  = shifting & (cpha ? trail_edge : lead_edge);
  assign do_shift   = shifting & (cpha ? lead_edge : trail_edge) & (bitcnt != 4'd0) & (bitcnt != 4'd8);
  assign frame_done = do_sample & (bitcnt == 4'd7);
  // deselect before any bit was clocked (e.g. right after a completed frame) is not an abort
  assign abort      = shifting & ss_rise & (bitcnt != 4'd0);
  assign rx_byte    = rx_sr;

  // Load the TX byte and first miso bit, then shift in on sample edges and out on shift edges
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      tx_sr  <= '0;
      rx_sr  <= '0;
      bitcnt <= '0;
      miso   <= 1'b0;
    end else if (load) begin
      tx_sr  <= load_byte;
      miso   <= lsbfe ? load_byte[0] : load_byte[7];
      bitcnt <= '0;
    end else begin
      if (do_sample) begin
        rx_sr  <= lsbfe ? {mosi_s, rx_sr[7:1]} : {rx_sr[6:0], mosi_s};
        bitcnt <= bitcnt + 4'd1;
      end
      if (do_shift) begin
        tx_sr <= lsbfe ? {1'b0, tx_sr[7:1]} : {tx_sr[6:0], 1'b0};
        miso  <= lsbfe ? tx_sr[1] : tx_sr[6];
      end
    end
  end

endmodule

// File: rtl/spi_slave_apb.sv
// SPI responder with APB register file (CR/SR/DR), frame FSM and interrupt.
// Latency: APB zero wait states; RXF set <= SYNC_STAGES+2 PCLK after last sample edge.
// Backpressure: none on APB (PREADY=1); DR write while TX full is rejected with PSLVERR.
module spi_slave_apb
  import spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_FILL   = 8'h00
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic [2:0] PADDR,
  input  logic       PWRITE,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR,
  input  logic       sclk,
  input  logic       ss,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic       spi_interrupt_request
);

  logic [7:0] cr, tx_buf, rx_buf, sr_rd, rx_byte, load_byte;
  logic       rxf, txe, ovr, abrt;
  spi_state_t state, state_nxt;
  logic       ss_low, ss_fall, ss_rise, frame_done, abort;
  logic       load, shifting, done;
  logic       apb_access, addr_ok, wr_ok, dr_rd;

  assign apb_access = PSEL & PENABLE;
  assign addr_ok    = (PADDR == ADDR_CR) | (PADDR == ADDR_SR) | (PADDR == ADDR_DR);
  assign PSLVERR    = apb_access & (~addr_ok | (PWRITE & (PADDR == ADDR_DR) & ~txe));
  assign wr_ok      = apb_access & PWRITE & ~PSLVERR;
  assign dr_rd      = apb_access & ~PWRITE & (PADDR == ADDR_DR);
  assign PREADY     = 1'b1;

  assign load      = (state == ST_LOAD);
  assign shifting  = (state == ST_SHIFT);
  assign done      = (state == ST_DONE);
  assign load_byte = txe ? IDLE_FILL : tx_buf;

  assign miso_oe               = cr[CR_SPE] & ss_low;
  assign spi_interrupt_request = cr[CR_SPIE] & (rxf | ovr | abrt);

  // Assemble the status register image
  always_comb begin
    sr_rd          = '0;
    sr_rd[SR_RXF]  = rxf;
    sr_rd[SR_TXE]  = txe;
    sr_rd[SR_OVR]  = ovr;
    sr_rd[SR_ABRT] = abrt;
  end

  // Read mux; PRDATA is zero outside a read access phase and for unmapped addresses
  always_comb begin
    PRDATA = '0;
    if (apb_access && !PWRITE) begin
      case (PADDR)
        ADDR_CR: PRDATA = cr;
        ADDR_SR: PRDATA = sr_rd;
        ADDR_DR: PRDATA = rx_buf;
        default: PRDATA = '0;
      endcase
    end
  end

  // Frame state register
  always_ff @(posedge PCLK) begin
    if (!PRESETn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; deselect during LOAD/SHIFT drops the frame
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cr[CR_SPE] && ss_fall) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ss_rise ? ST_IDLE : ST_SHIFT;
      ST_SHIFT: begin
        if (ss_rise)         state_nxt = ST_IDLE;
        else if (frame_done) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = (ss_low && cr[CR_SPE]) ? ST_LOAD : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Registers: CPU accesses first, engine events afterwards so they win on collision
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      cr     <= '0;
      tx_buf <= '0;
      rx_buf <= '0;
      rxf    <= 1'b0;
      txe    <= 1'b1;
      ovr    <= 1'b0;
      abrt   <= 1'b0;
    end else begin
      if (wr_ok && PADDR == ADDR_CR) cr <= PWDATA & CR_MASK;
      if (wr_ok && PADDR == ADDR_SR) begin
        if (PWDATA[SR_OVR])  ovr  <= 1'b0;
        if (PWDATA[SR_ABRT]) abrt <= 1'b0;
      end
      if (dr_rd) rxf <= 1'b0;
      // LOAD consumes the old buffer; a same-cycle DR write (only legal when empty) lands after
      if (load && !txe) txe <= 1'b1;
      if (wr_ok && PADDR == ADDR_DR) begin
        tx_buf <= PWDATA;
        txe    <= 1'b0;
      end
      // A DR read in the DONE cycle has consumed the old byte, so the new one is kept
      if (done) begin
        if (rxf && !dr_rd) ovr <= 1'b1;
        else               rx_buf <= rx_byte;
        rxf <= 1'b1;
      end
      if (abort) abrt <= 1'b1;
    end
  end

  spi_slave_shifter #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_shifter (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .sclk       (sclk),
    .ss         (ss),
    .mosi       (mosi),
    .cpol       (cr[CR_CPOL]),
    .cpha       (cr[CR_CPHA]),
    .lsbfe      (cr[CR_LSBFE]),
    .load       (load),
    .load_byte  (load_byte),
    .shifting   (shifting),
    .ss_low     (ss_low),
    .ss_fall    (ss_fall),
    .ss_rise    (ss_rise),
    .frame_done (frame_done),
    .abort      (abort),
    .miso       (miso),
    .rx_byte    (rx_byte)
  );

endmodule

// File: tb/tb_spi_slave_apb.sv
// Directed bench for spi_slave_apb: APB master plus SPI master model, hand-computed expectations.
// Latency: SPI master runs at PCLK/16 so every synchronizer delay fits inside a half period.
// Backpressure: n/a.
module tb_spi_slave_apb;

  localparam logic [2:0] A_CR  = 3'b000;
  localparam logic [2:0] A_SR  = 3'b011;
  localparam logic [2:0] A_DR  = 3'b101;
  localparam logic [2:0] A_BAD = 3'b111;
  localparam int H = 8;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic [2:0] PADDR;
  logic       PWRITE, PSEL, PENABLE;
  logic [7:0] PWDATA, PRDATA;
  logic       PREADY, PSLVERR;
  logic       sclk, ss, mosi, miso, miso_oe, irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rcv;
  logic       oe_ok;

  spi_slave_apb #(.SYNC_STAGES(2), .IDLE_FILL(8'h00)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
    .spi_interrupt_request(irq)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 8'h%02h expected 8'h%02h", tag, obs, exp);
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [2:0] a, input logic [7:0] wd,
                          output logic [7:0] rd, output logic err);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #3;
    rd  = PRDATA;
    err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp, input logic exp_err);
    logic [7:0] d;
    logic       e;
    apb_xfer(1'b0, a, 8'h00, d, e);
    check(tag, d, exp);
    check({tag, "_slverr"}, {7'b0, e}, {7'b0, exp_err});
  endtask

  task automatic wr_chk(input string tag, input logic [2:0] a, input logic [7:0] wd, input logic exp_err);
    logic [7:0] d;
    logic       e;
    apb_xfer(1'b1, a, wd, d, e);
    check({tag, "_slverr"}, {7'b0, e}, {7'b0, exp_err});
  endtask

  // SPI master: sends tx, records miso per bit, stops after nedges sclk edges
  task automatic spi_frame(input logic [7:0] tx, input logic cpol, input logic cpha, input logic lsbfe,
                           input int nedges, input logic hold_ss,
                           output logic [7:0] got, output logic oe);
    int e;
    int idx;
    got = 8'h00;
    oe  = 1'b1;
    e   = 0;
    sclk = cpol;
    repeat (H) @(posedge PCLK); #1;
    ss = 1'b0;
    if (!cpha) mosi = lsbfe ? tx[0] : tx[7];
    for (int i = 0; i < 8 && e < nedges; i++) begin
      idx = lsbfe ? i : 7 - i;
      repeat (H) @(posedge PCLK); #1;
      oe = oe & miso_oe;
      if (!cpha) got[idx] = miso;
      else       mosi = tx[idx];
      sclk = ~cpol;
      e++;
      if (e < nedges) begin
        repeat (H) @(posedge PCLK); #1;
        if (cpha) got[idx] = miso;
        sclk = cpol;
        e++;
        if (!cpha && i < 7) mosi = lsbfe ? tx[i+1] : tx[6-i];
      end
    end
    repeat (H) @(posedge PCLK); #1;
    if (!hold_ss) begin
      ss = 1'b1;
      repeat (2*H) @(posedge PCLK); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESETn = 1'b0; PADDR = 3'b000; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWDATA = 8'h00;
    sclk = 1'b0; ss = 1'b1; mosi = 1'b0;
    repeat (4) @(posedge PCLK); #1;
    PRESETn = 1'b1;
    repeat (2) @(posedge PCLK); #1;

    // 1: reset state
    check("rst_prdata", PRDATA, 8'h00);
    check("rst_pready", {7'b0, PREADY}, 8'h01);
    check("rst_pslverr", {7'b0, PSLVERR}, 8'h00);
    check("rst_miso", {7'b0, miso}, 8'h00);
    check("rst_miso_oe", {7'b0, miso_oe}, 8'h00);
    check("rst_irq", {7'b0, irq}, 8'h00);
    rd_chk("rst_sr", A_SR, 8'h20, 1'b0);
    rd_chk("rst_cr", A_CR, 8'h00, 1'b0);
    rd_chk("rst_dr", A_DR, 8'h00, 1'b0);

    // 2: mode 1 (CPHA=1), MSB first, TX 65, RX B9
    wr_chk("t2_cr", A_CR, 8'h44, 1'b0);
    rd_chk("t2_cr_rd", A_CR, 8'h44, 1'b0);
    wr_chk("t2_dr", A_DR, 8'h65, 1'b0);
    rd_chk("t2_sr_loaded", A_SR, 8'h00, 1'b0);
    spi_frame(8'hB9, 1'b0, 1'b1, 1'b0, 16, 1'b0, rcv, oe_ok);
    check("t2_miso", rcv, 8'h65);
    check("t2_oe_during", {7'b0, oe_ok}, 8'h01);
    check("t2_oe_after", {7'b0, miso_oe}, 8'h00);
    rd_chk("t2_sr_rxf", A_SR, 8'hA0, 1'b0);
    check("t2_irq", {7'b0, irq}, 8'h00);
    rd_chk("t2_dr", A_DR, 8'hB9, 1'b0);
    rd_chk("t2_sr_clr", A_SR, 8'h20, 1'b0);

    // 3: CPOL=1 CPHA=0 LSB first, TX empty
    wr_chk("t3_cr", A_CR, 8'h49, 1'b0);
    spi_frame(8'h3C, 1'b1, 1'b0, 1'b1, 16, 1'b0, rcv, oe_ok);
    check("t3_miso_fill", rcv, 8'h00);
    rd_chk("t3_sr", A_SR, 8'hA0, 1'b0);
    rd_chk("t3_dr", A_DR, 8'h3C, 1'b0);

    // 4: back-to-back A5, 5A without DR read -> overrun
    wr_chk("t4_cr", A_CR, 8'hC0, 1'b0);
    spi_frame(8'hA5, 1'b0, 1'b0, 1'b0, 16, 1'b1, rcv, oe_ok);
    spi_frame(8'h5A, 1'b0, 1'b0, 1'b0, 16, 1'b0, rcv, oe_ok);
    rd_chk("t4_sr_ovr", A_SR, 8'hB0, 1'b0);
    check("t4_irq_set", {7'b0, irq}, 8'h01);
    rd_chk("t4_dr", A_DR, 8'hA5, 1'b0);
    rd_chk("t4_sr_rd", A_SR, 8'h30, 1'b0);
    check("t4_irq_ovr", {7'b0, irq}, 8'h01);
    wr_chk("t4_w1c", A_SR, 8'h10, 1'b0);
    rd_chk("t4_sr_w1c", A_SR, 8'h20, 1'b0);
    check("t4_irq_clr", {7'b0, irq}, 8'h00);

    // 5: abort after 4 sclk edges, then full frame 81
    spi_frame(8'hFF, 1'b0, 1'b0, 1'b0, 4, 1'b0, rcv, oe_ok);
    rd_chk("t5_sr_abrt", A_SR, 8'h28, 1'b0);
    check("t5_irq_abrt", {7'b0, irq}, 8'h01);
    wr_chk("t5_w1c", A_SR, 8'h08, 1'b0);
    rd_chk("t5_sr_w1c", A_SR, 8'h20, 1'b0);
    spi_frame(8'h81, 1'b0, 1'b0, 1'b0, 16, 1'b0, rcv, oe_ok);
    rd_chk("t5_sr_rxf", A_SR, 8'hA0, 1'b0);
    rd_chk("t5_dr", A_DR, 8'h81, 1'b0);

    // 6: bad address and DR write while TX full
    rd_chk("t6_bad_rd", A_BAD, 8'h00, 1'b1);
    wr_chk("t6_bad_wr", A_BAD, 8'hFF, 1'b1);
    rd_chk("t6_cr_kept", A_CR, 8'hC0, 1'b0);
    wr_chk("t6_dr_first", A_DR, 8'h11, 1'b0);
    wr_chk("t6_dr_full", A_DR, 8'h22, 1'b1);
    rd_chk("t6_sr_txfull", A_SR, 8'h00, 1'b0);
    spi_frame(8'h00, 1'b0, 1'b0, 1'b0, 16, 1'b0, rcv, oe_ok);
    check("t6_miso_kept", rcv, 8'h11);
    rd_chk("t6_sr_end", A_SR, 8'hA0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
